// File: rtl/nregister_pkg.sv
// Shared definitions for the NRegister serial link (serializer and deserializer).
package nregister_pkg;

    localparam int unsigned NREG_WIDTH = 8;

    typedef logic [0:0] nreg_state_t;

    localparam nreg_state_t IDLE  = 1'b0;
    localparam nreg_state_t SHIFT = 1'b1;

    // Beat counter must reach WIDTH when the parity beat is appended.
    function automatic int unsigned nreg_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/nregister_shift_out.sv
// Output shift register for the NRegister serializer: parallel load, zero-filled shift toward the output end.
module nregister_shift_out
    import nregister_pkg::*;
#(
    parameter int unsigned WIDTH     = NREG_WIDTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sreg_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q <= '0;
        end else if (load) begin
            sreg_q <= din;
        end else if (shift) begin
            if (LSB_FIRST) begin
                sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
            end else begin
                sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign dout = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];

endmodule

// File: rtl/nregister_serializer.sv
// Parallel-to-serial transmit end of the NRegister link; one word in flight at a time.
// Define NREGISTER_SERIALIZER_PARITY_EN to append an even-parity beat after each word.
module nregister_serializer
    import nregister_pkg::*;
#(
    parameter int unsigned WIDTH     = NREG_WIDTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_bits,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic             io_out_bit,
    output logic             io_out_last
);

    localparam int unsigned CNT_W = nreg_cnt_w(WIDTH);
`ifdef NREGISTER_SERIALIZER_PARITY_EN
    localparam int unsigned LAST_BEAT_I = WIDTH;
`else
    localparam int unsigned LAST_BEAT_I = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LAST_BEAT_I);

    nreg_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;
    logic             shift;
    logic             is_last;
    logic             data_bit;
    logic             serial_bit;

    assign is_last = (cnt_q == LAST_BEAT);

    // State and beat counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and shift-control decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (io_out_ready) begin
                    shift = 1'b1;
                    if (is_last) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    nregister_shift_out #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_out (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .shift   (shift),
        .din     (io_in_bits),
        .dout    (data_bit)
    );

`ifdef NREGISTER_SERIALIZER_PARITY_EN
    logic parity_q;

    // Even parity of the word, captured at load and sent on the extra beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^io_in_bits;
        end
    end

    assign serial_bit = is_last ? parity_q : data_bit;
`else
    assign serial_bit = data_bit;
`endif

    assign io_in_ready  = (state_q == IDLE);
    assign io_out_valid = (state_q == SHIFT);
    assign io_out_bit   = (state_q == SHIFT) && serial_bit;
    assign io_out_last  = (state_q == SHIFT) && is_last;

endmodule

// File: tb/tb_nregister_serializer.sv
// Directed bench for nregister_serializer: LSB/MSB order, backpressure, back-to-back, reset, parity.
module tb_nregister_serializer;

`ifdef NREGISTER_SERIALIZER_PARITY_EN
    localparam int NBEATS = 9;
`else
    localparam int NBEATS = 8;
`endif

    logic       clk;
    logic       reset_n;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_bit, a_out_last;
    logic [7:0] a_in_bits;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_bit, b_out_last;
    logic [7:0] b_in_bits;

    int errors = 0;
    int checks = 0;

    nregister_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_lsb (
        .clk          (clk),
        .reset_n      (reset_n),
        .io_in_valid  (a_in_valid),
        .io_in_ready  (a_in_ready),
        .io_in_bits   (a_in_bits),
        .io_out_valid (a_out_valid),
        .io_out_ready (a_out_ready),
        .io_out_bit   (a_out_bit),
        .io_out_last  (a_out_last)
    );

    nregister_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk          (clk),
        .reset_n      (reset_n),
        .io_in_valid  (b_in_valid),
        .io_in_ready  (b_in_ready),
        .io_in_bits   (b_in_bits),
        .io_out_valid (b_out_valid),
        .io_out_ready (b_out_ready),
        .io_out_bit   (b_out_bit),
        .io_out_last  (b_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Send one word through the LSB-first instance; called and returns on a falling edge.
    task automatic run_word_a(input logic [7:0] w, input bit bp, output logic last_bit);
        logic [7:0]  rx;
        logic [15:0] pat;
        logic        exp_bit, hb, hl;
        int          beats, cyc;
        bit          hold;
        pat = 16'b1011_0110_1101_1001;
        check("in_ready_idle", 32'(a_in_ready), 32'd1);
        check("out_valid_idle", 32'(a_out_valid), 32'd0);
        a_in_valid = 1'b1;
        a_in_bits  = w;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_bits  = ~w;
        rx = '0; beats = 0; cyc = 0; hold = 1'b0; hb = 1'b0; hl = 1'b0; last_bit = 1'b0;
        while (beats < NBEATS && cyc < 64) begin
            check("out_valid", 32'(a_out_valid), 32'd1);
            check("in_ready_busy", 32'(a_in_ready), 32'd0);
            if (hold) begin
                check("hold_bit", 32'(a_out_bit), 32'(hb));
                check("hold_last", 32'(a_out_last), 32'(hl));
            end
            a_out_ready = bp ? pat[cyc % 16] : 1'b1;
            if (a_out_ready) begin
                exp_bit = (beats < 8) ? w[beats] : ^w;
                check("bit", 32'(a_out_bit), 32'(exp_bit));
                check("last", 32'(a_out_last), 32'(beats == NBEATS - 1));
                if (beats < 8) rx[beats] = a_out_bit;
                last_bit = a_out_bit;
                beats++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
                hb   = a_out_bit;
                hl   = a_out_last;
            end
            cyc++;
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        check("beats", 32'(beats), 32'(NBEATS));
        check("rx_word", 32'(rx), 32'(w));
        if (!bp) check("cycles", 32'(cyc), 32'(NBEATS));
        check("in_ready_after", 32'(a_in_ready), 32'd1);
        check("out_valid_after", 32'(a_out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] rx;
        logic       lb;
        logic       exp_bit;

        reset_n = 1'b0;
        a_in_valid = 1'b0; a_in_bits = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_bits = '0; b_out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_bit", 32'(a_out_bit), 32'd0);
        check("rst_out_last", 32'(a_out_last), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic LSB-first, A5 = bits 1,0,1,0,0,1,0,1
        run_word_a(8'hA5, 1'b0, lb);

        // Backpressure
        run_word_a(8'h3C, 1'b1, lb);

        // MSB-first on the second instance
        w = 8'h81;
        rx = '0;
        b_in_valid = 1'b1;
        b_in_bits  = w;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_bits  = 8'h00;
        check("msb_first_bit", 32'(b_out_bit), 32'd1);
        for (int i = 0; i < NBEATS; i++) begin
            exp_bit = (i < 8) ? w[7 - i] : ^w;
            check("msb_valid", 32'(b_out_valid), 32'd1);
            check("msb_bit", 32'(b_out_bit), 32'(exp_bit));
            check("msb_last", 32'(b_out_last), 32'(i == NBEATS - 1));
            if (i < 8) rx = {rx[6:0], b_out_bit};
            @(negedge clk);
        end
        check("msb_rx", 32'(rx), 32'h81);
        check("msb_idle", 32'(b_in_ready), 32'd1);

        // Back-to-back: in_valid held high across two words
        w = 8'h01;
        a_in_valid = 1'b1;
        a_in_bits  = w;
        @(negedge clk);
        a_in_bits = 8'hFF;
        for (int i = 0; i < NBEATS; i++) begin
            exp_bit = (i < 8) ? w[i] : ^w;
            check("b2b1_in_ready", 32'(a_in_ready), 32'd0);
            check("b2b1_bit", 32'(a_out_bit), 32'(exp_bit));
            @(negedge clk);
        end
        check("b2b_gap_in_ready", 32'(a_in_ready), 32'd1);
        check("b2b_gap_out_valid", 32'(a_out_valid), 32'd0);
        @(negedge clk);
        a_in_valid = 1'b0;
        w = 8'hFF;
        for (int i = 0; i < NBEATS; i++) begin
            exp_bit = (i < 8) ? w[i] : ^w;
            check("b2b2_in_ready", 32'(a_in_ready), 32'd0);
            check("b2b2_bit", 32'(a_out_bit), 32'(exp_bit));
            check("b2b2_last", 32'(a_out_last), 32'(i == NBEATS - 1));
            @(negedge clk);
        end
        check("b2b_end_in_ready", 32'(a_in_ready), 32'd1);

        // Reset mid-word after 3 accepted beats of F0
        a_in_valid = 1'b1;
        a_in_bits  = 8'hF0;
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", 32'(a_out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(a_out_valid), 32'd0);
        check("async_rst_in_ready", 32'(a_in_ready), 32'd1);
        check("async_rst_out_last", 32'(a_out_last), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", 32'(a_out_valid), 32'd0);
        run_word_a(8'h0F, 1'b0, lb);

`ifdef NREGISTER_SERIALIZER_PARITY_EN
        run_word_a(8'h07, 1'b0, lb);
        check("parity_07", 32'(lb), 32'd1);
        run_word_a(8'h03, 1'b0, lb);
        check("parity_03", 32'(lb), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nregister_serializer.md
Name: nregister_serializer

Overview:
- Transmit end for the parallel NRegister capture path: accepts one WIDTH-bit word over a valid/ready handshake and emits it one bit per beat on a valid/ready serial stream.
- The receiving side deserializes the stream back into an N-bit register.
- Sits between a parallel producer and the serial link. Only one word is in flight at a time.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- io_in_valid  input  1  parallel word offered.
- io_in_ready  output  1  serializer can accept a word.
- io_in_bits  input  WIDTH  parallel word.
- io_out_valid  output  1  serial bit valid.
- io_out_ready  input  1  downstream accepts the bit.
- io_out_bit  output  1  current serial bit.
- io_out_last  output  1  current beat is the final beat of the word.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, shift register=0, beat counter=0.
  - Outputs: io_in_ready=1, io_out_valid=0, io_out_bit=0, io_out_last=0.
- State IDLE:
  - io_in_ready=1, io_out_valid=0.
  - On io_in_valid && io_in_ready: load io_in_bits into the shift register, clear the counter, go to SHIFT.
- State SHIFT:
  - io_in_ready=0 and io_out_valid=1.
  - io_out_bit is sreg[0] if LSB_FIRST=1, else sreg[WIDTH-1].
  - io_out_last=1 when the counter equals LAST_BEAT. LAST_BEAT=WIDTH-1, or WIDTH when the parity feature is enabled.
  - On io_out_ready: shift one position toward the output end, zero-fill, and increment the counter.
  - If io_out_ready arrives while io_out_last=1: return to IDLE and clear the counter.
- Latency and throughput:
  - The first bit is valid the cycle after the input handshake.
  - A word takes WIDTH accepted beats (WIDTH+1 with parity), plus 1 IDLE cycle before the next word.
  - Peak throughput is therefore 1 word per WIDTH+1 cycles.
- Backpressure:
  - With io_out_ready=0, io_out_bit, io_out_last and io_out_valid hold stable.
  - io_out_valid never drops once asserted until the bit is accepted.
- io_in_bits is sampled only on the handshake cycle; later changes have no effect on the word in flight.
- Reset asserted mid-word aborts the word immediately. No partial beat is emitted after reset deasserts.
- Counter width is clog2(WIDTH+1). Its only legal values are 0..LAST_BEAT.
- Outputs are driven from registered state through combinational decode only. There is no combinational path from io_in_* to io_out_*.

Optional Feature:
- Macro: NREGISTER_SERIALIZER_PARITY_EN.
- Defined:
  - The word is followed by one extra beat carrying even parity (XOR of all WIDTH data bits), computed at load and held in a parity register.
  - io_out_last is asserted on the parity beat only.
- Undefined:
  - There is no parity register and no extra beat.
  - io_out_last is asserted on data bit WIDTH-1.

Decomposition:
- Shared package nregister_pkg holds:
  - state enum (IDLE=1'b0, SHIFT=1'b1);
  - localparam function for the counter width;
  - default NREG_WIDTH=8.
- The receiver-side deserializer uses the same package.
- One natural sub-module: nregister_shift_out. It contains the shift register, the output-end select and zero-fill. The FSM, counter and handshake logic stay in the top module.

Test Plan:
- Basic LSB-first:
  - Stimulus: WIDTH=8, reset released, io_out_ready=1, word 8'hA5 accepted.
  - Required: bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; io_out_last on the 8th; io_in_ready returns to 1 the next cycle.
- MSB-first:
  - Stimulus: LSB_FIRST=0, word 8'h81.
  - Required: bits 1,0,0,0,0,0,0,1; reconstructed value 8'h81.
- Backpressure:
  - Stimulus: word 8'h3C; io_out_ready toggles 1,0,0,1,... pseudo-randomly.
  - Required: io_out_bit and io_out_last stable while ready=0; exactly 8 accepted beats; reassembled value 8'h3C.
- Back-to-back words:
  - Stimulus: io_in_valid held high with 8'h01 then 8'hFF.
  - Required: second handshake occurs only in the IDLE cycle after the first word's last beat; io_in_ready=0 throughout SHIFT.
- Reset mid-word:
  - Stimulus: reset_n pulsed low after 3 beats of 8'hF0.
  - Required: io_out_valid=0 and io_in_ready=1 immediately (asynchronous); the next word 8'h0F serializes cleanly from bit 0.
- Parity (macro defined):
  - Stimulus: word 8'h07.
  - Required: 8 data beats, then a 9th beat with bit=1 and io_out_last=1; for word 8'h03 the 9th beat is 0.
